// File: rtl/axilite_arb2.sv
// Two-requester AXI-Lite arbiter: S0/S1 share one downstream M port, one transaction at a time.
// Round-robin between requesters; read/write alternation within a requester.
module axilite_arb2 #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESETN,
    // requester 0
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S0_AXI_ARADDR,
    input  logic [2:0]                    S0_AXI_ARPROT,
    input  logic                          S0_AXI_ARVALID,
    output logic                          S0_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S0_AXI_RDATA,
    output logic [1:0]                    S0_AXI_RRESP,
    output logic                          S0_AXI_RVALID,
    input  logic                          S0_AXI_RREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S0_AXI_AWADDR,
    input  logic [2:0]                    S0_AXI_AWPROT,
    input  logic                          S0_AXI_AWVALID,
    output logic                          S0_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S0_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S0_AXI_WSTRB,
    input  logic                          S0_AXI_WVALID,
    output logic                          S0_AXI_WREADY,
    output logic [1:0]                    S0_AXI_BRESP,
    output logic                          S0_AXI_BVALID,
    input  logic                          S0_AXI_BREADY,
    // requester 1
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S1_AXI_ARADDR,
    input  logic [2:0]                    S1_AXI_ARPROT,
    input  logic                          S1_AXI_ARVALID,
    output logic                          S1_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S1_AXI_RDATA,
    output logic [1:0]                    S1_AXI_RRESP,
    output logic                          S1_AXI_RVALID,
    input  logic                          S1_AXI_RREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S1_AXI_AWADDR,
    input  logic [2:0]                    S1_AXI_AWPROT,
    input  logic                          S1_AXI_AWVALID,
    output logic                          S1_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S1_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S1_AXI_WSTRB,
    input  logic                          S1_AXI_WVALID,
    output logic                          S1_AXI_WREADY,
    output logic [1:0]                    S1_AXI_BRESP,
    output logic                          S1_AXI_BVALID,
    input  logic                          S1_AXI_BREADY,
    // shared downstream
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int unsigned DW = C_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_AXI_ADDR_WIDTH;
    localparam int unsigned SW = C_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB} state_e;

    state_e     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       rr_q, rr_d;
    logic [1:0] last_op_q, last_op_d;  // 1 = last completed op was a write
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [AW-1:0] s_araddr [2];
    logic [AW-1:0] s_awaddr [2];
    logic [2:0]    s_arprot [2];
    logic [2:0]    s_awprot [2];
    logic [DW-1:0] s_wdata  [2];
    logic [SW-1:0] s_wstrb  [2];
    logic [1:0]    s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [1:0]    s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DW-1:0] s_rdata  [2];
    logic [1:0]    s_rresp  [2];
    logic [1:0]    s_bresp  [2];

    assign s_araddr[0] = S0_AXI_ARADDR;
    assign s_araddr[1] = S1_AXI_ARADDR;
    assign s_arprot[0] = S0_AXI_ARPROT;
    assign s_arprot[1] = S1_AXI_ARPROT;
    assign s_awaddr[0] = S0_AXI_AWADDR;
    assign s_awaddr[1] = S1_AXI_AWADDR;
    assign s_awprot[0] = S0_AXI_AWPROT;
    assign s_awprot[1] = S1_AXI_AWPROT;
    assign s_wdata[0]  = S0_AXI_WDATA;
    assign s_wdata[1]  = S1_AXI_WDATA;
    assign s_wstrb[0]  = S0_AXI_WSTRB;
    assign s_wstrb[1]  = S1_AXI_WSTRB;
    assign s_arvalid   = {S1_AXI_ARVALID, S0_AXI_ARVALID};
    assign s_rready    = {S1_AXI_RREADY, S0_AXI_RREADY};
    assign s_awvalid   = {S1_AXI_AWVALID, S0_AXI_AWVALID};
    assign s_wvalid    = {S1_AXI_WVALID, S0_AXI_WVALID};
    assign s_bready    = {S1_AXI_BREADY, S0_AXI_BREADY};

    assign {S1_AXI_ARREADY, S0_AXI_ARREADY} = s_arready;
    assign {S1_AXI_RVALID, S0_AXI_RVALID}   = s_rvalid;
    assign {S1_AXI_AWREADY, S0_AXI_AWREADY} = s_awready;
    assign {S1_AXI_WREADY, S0_AXI_WREADY}   = s_wready;
    assign {S1_AXI_BVALID, S0_AXI_BVALID}   = s_bvalid;
    assign S0_AXI_RDATA = s_rdata[0];
    assign S1_AXI_RDATA = s_rdata[1];
    assign S0_AXI_RRESP = s_rresp[0];
    assign S1_AXI_RRESP = s_rresp[1];
    assign S0_AXI_BRESP = s_bresp[0];
    assign S1_AXI_BRESP = s_bresp[1];

    logic [1:0] rd_pend, wr_pend, pend;
    logic       sel, pick_rd, aw_fire, w_fire;

    assign rd_pend = s_arvalid;
    assign wr_pend = s_awvalid & s_wvalid;
    assign pend    = rd_pend | wr_pend;
    assign sel     = pend[rr_q] ? rr_q : ~rr_q;
    // Read wins when it is the only pending op, or when both pend and the last op was a write.
    assign pick_rd = rd_pend[sel] & (~wr_pend[sel] | last_op_q[sel]);
    assign aw_fire = s_awvalid[gnt_q] & ~aw_done_q & M_AXI_AWREADY;
    assign w_fire  = s_wvalid[gnt_q] & ~w_done_q & M_AXI_WREADY;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        rr_d          = rr_q;
        last_op_d     = last_op_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        M_AXI_ARADDR  = '0;
        M_AXI_ARPROT  = '0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWADDR  = '0;
        M_AXI_AWPROT  = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WDATA   = '0;
        M_AXI_WSTRB   = '0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        s_arready     = '0;
        s_rvalid      = '0;
        s_awready     = '0;
        s_wready      = '0;
        s_bvalid      = '0;
        s_rdata[0]    = '0;
        s_rdata[1]    = '0;
        s_rresp[0]    = '0;
        s_rresp[1]    = '0;
        s_bresp[0]    = '0;
        s_bresp[1]    = '0;
        unique case (state_q)
            StIdle: begin
                if (pend[sel]) begin
                    gnt_d   = sel;
                    state_d = pick_rd ? StRdA : StWrAw;
                end
            end
            StRdA: begin
                M_AXI_ARADDR     = s_araddr[gnt_q];
                M_AXI_ARPROT     = s_arprot[gnt_q];
                M_AXI_ARVALID    = s_arvalid[gnt_q];
                s_arready[gnt_q] = M_AXI_ARREADY;
                if (s_arvalid[gnt_q] && M_AXI_ARREADY) state_d = StRdD;
            end
            StRdD: begin
                s_rdata[gnt_q]  = M_AXI_RDATA;
                s_rresp[gnt_q]  = M_AXI_RRESP;
                s_rvalid[gnt_q] = M_AXI_RVALID;
                M_AXI_RREADY    = s_rready[gnt_q];
                if (M_AXI_RVALID && s_rready[gnt_q]) begin
                    state_d          = StIdle;
                    rr_d             = ~gnt_q;
                    last_op_d[gnt_q] = 1'b0;
                end
            end
            StWrAw: begin
                M_AXI_AWADDR     = s_awaddr[gnt_q];
                M_AXI_AWPROT     = s_awprot[gnt_q];
                M_AXI_AWVALID    = s_awvalid[gnt_q] & ~aw_done_q;
                s_awready[gnt_q] = M_AXI_AWREADY & ~aw_done_q;
                M_AXI_WDATA      = s_wdata[gnt_q];
                M_AXI_WSTRB      = s_wstrb[gnt_q];
                M_AXI_WVALID     = s_wvalid[gnt_q] & ~w_done_q;
                s_wready[gnt_q]  = M_AXI_WREADY & ~w_done_q;
                aw_done_d        = aw_done_q | aw_fire;
                w_done_d         = w_done_q | w_fire;
                if (aw_done_d && w_done_d) state_d = StWrB;
            end
            StWrB: begin
                s_bresp[gnt_q]  = M_AXI_BRESP;
                s_bvalid[gnt_q] = M_AXI_BVALID;
                M_AXI_BREADY    = s_bready[gnt_q];
                if (M_AXI_BVALID && s_bready[gnt_q]) begin
                    state_d          = StIdle;
                    rr_d             = ~gnt_q;
                    last_op_d[gnt_q] = 1'b1;
                    aw_done_d        = 1'b0;
                    w_done_d         = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            rr_q      <= 1'b0;
            last_op_q <= 2'b11;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            last_op_q <= last_op_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axilite_arb2.sv
// Bench for axilite_arb2: directed requester traffic, a behavioural downstream slave, and
// queue-based scoreboards checked by a negedge monitor.
module tb_axilite_arb2;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [AW-1:0] s_araddr [2];
    logic [AW-1:0] s_awaddr [2];
    logic [2:0]    s_arprot [2];
    logic [2:0]    s_awprot [2];
    logic [DW-1:0] s_wdata  [2];
    logic [3:0]    s_wstrb  [2];
    logic [1:0]    s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DW-1:0] s_rdata  [2];
    logic [1:0]    s_rresp  [2];
    logic [1:0]    s_bresp  [2];

    logic [AW-1:0] m_araddr, m_awaddr;
    logic [2:0]    m_arprot, m_awprot;
    logic          m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic          m_wvalid, m_wready, m_bvalid, m_bready;
    logic [DW-1:0] m_rdata, m_wdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_rresp, m_bresp;

    axilite_arb2 #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .S0_AXI_ARADDR(s_araddr[0]), .S0_AXI_ARPROT(s_arprot[0]), .S0_AXI_ARVALID(s_arvalid[0]),
        .S0_AXI_ARREADY(s_arready[0]), .S0_AXI_RDATA(s_rdata[0]), .S0_AXI_RRESP(s_rresp[0]),
        .S0_AXI_RVALID(s_rvalid[0]), .S0_AXI_RREADY(s_rready[0]), .S0_AXI_AWADDR(s_awaddr[0]),
        .S0_AXI_AWPROT(s_awprot[0]), .S0_AXI_AWVALID(s_awvalid[0]), .S0_AXI_AWREADY(s_awready[0]),
        .S0_AXI_WDATA(s_wdata[0]), .S0_AXI_WSTRB(s_wstrb[0]), .S0_AXI_WVALID(s_wvalid[0]),
        .S0_AXI_WREADY(s_wready[0]), .S0_AXI_BRESP(s_bresp[0]), .S0_AXI_BVALID(s_bvalid[0]),
        .S0_AXI_BREADY(s_bready[0]),
        .S1_AXI_ARADDR(s_araddr[1]), .S1_AXI_ARPROT(s_arprot[1]), .S1_AXI_ARVALID(s_arvalid[1]),
        .S1_AXI_ARREADY(s_arready[1]), .S1_AXI_RDATA(s_rdata[1]), .S1_AXI_RRESP(s_rresp[1]),
        .S1_AXI_RVALID(s_rvalid[1]), .S1_AXI_RREADY(s_rready[1]), .S1_AXI_AWADDR(s_awaddr[1]),
        .S1_AXI_AWPROT(s_awprot[1]), .S1_AXI_AWVALID(s_awvalid[1]), .S1_AXI_AWREADY(s_awready[1]),
        .S1_AXI_WDATA(s_wdata[1]), .S1_AXI_WSTRB(s_wstrb[1]), .S1_AXI_WVALID(s_wvalid[1]),
        .S1_AXI_WREADY(s_wready[1]), .S1_AXI_BRESP(s_bresp[1]), .S1_AXI_BVALID(s_bvalid[1]),
        .S1_AXI_BREADY(s_bready[1]),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid),
        .M_AXI_ARREADY(m_arready), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
        .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready), .M_AXI_AWADDR(m_awaddr),
        .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid),
        .M_AXI_WREADY(m_wready), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid),
        .M_AXI_BREADY(m_bready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT, got no response, expected one", name);
    endtask

    // Scoreboards: M-side {wr, addr}, W {strb, data}, per-requester R {resp, data} and B resp.
    logic [8:0]  exp_m  [$];
    logic [35:0] exp_w  [$];
    logic [33:0] exp_r0 [$];
    logic [33:0] exp_r1 [$];
    logic [1:0]  exp_b0 [$];
    logic [1:0]  exp_b1 [$];

    logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [AW-1:0] cap_araddr;
    int            overlap = 0;
    int            wv_cycles = 0;
    int            s1_act = 0;

    initial begin
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; cap_araddr = '0;
        forever begin
            @(negedge clk);
            ar_hs = m_arvalid & m_arready;
            r_hs  = m_rvalid & m_rready;
            aw_hs = m_awvalid & m_awready;
            w_hs  = m_wvalid & m_wready;
            b_hs  = m_bvalid & m_bready;
            if (m_arvalid && (m_awvalid || m_wvalid)) overlap++;
            if (m_wvalid) wv_cycles++;
            if (|{s_arready[1], s_rvalid[1], s_awready[1], s_wready[1], s_bvalid[1]}) s1_act++;
            if (ar_hs) begin
                cap_araddr = m_araddr;
                check("m_ar_expected", 64'(exp_m.size() != 0), 64'd1);
                if (exp_m.size() != 0) check("m_ar", {1'b0, m_araddr}, exp_m.pop_front());
            end
            if (aw_hs) begin
                check("m_aw_expected", 64'(exp_m.size() != 0), 64'd1);
                if (exp_m.size() != 0) check("m_aw", {1'b1, m_awaddr}, exp_m.pop_front());
            end
            if (w_hs) begin
                check("m_w_expected", 64'(exp_w.size() != 0), 64'd1);
                if (exp_w.size() != 0) check("m_w", {m_wstrb, m_wdata}, exp_w.pop_front());
            end
            if (s_rvalid[0] && s_rready[0]) begin
                check("s0_r_expected", 64'(exp_r0.size() != 0), 64'd1);
                if (exp_r0.size() != 0) check("s0_r", {s_rresp[0], s_rdata[0]}, exp_r0.pop_front());
            end
            if (s_rvalid[1] && s_rready[1]) begin
                check("s1_r_expected", 64'(exp_r1.size() != 0), 64'd1);
                if (exp_r1.size() != 0) check("s1_r", {s_rresp[1], s_rdata[1]}, exp_r1.pop_front());
            end
            if (s_bvalid[0] && s_bready[0]) begin
                check("s0_b_expected", 64'(exp_b0.size() != 0), 64'd1);
                if (exp_b0.size() != 0) check("s0_bresp", 64'(s_bresp[0]), 64'(exp_b0.pop_front()));
            end
            if (s_bvalid[1] && s_bready[1]) begin
                check("s1_b_expected", 64'(exp_b1.size() != 0), 64'd1);
                if (exp_b1.size() != 0) check("s1_bresp", 64'(s_bresp[1]), 64'(exp_b1.pop_front()));
            end
        end
    end

    // Downstream slave: ready after a programmable wait, read data from a small memory.
    logic [DW-1:0] mem [256];
    int            ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic [1:0]    slv_rresp = 2'b00, slv_bresp = 2'b00;

    initial begin
        int  ar_cnt, aw_cnt, w_cnt;
        logic aw_got, w_got;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
                m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
            end else begin
                if (b_hs) m_bvalid = 0;
                if (r_hs) m_rvalid = 0;
                if (ar_hs) begin
                    m_arready = 0; ar_cnt = 0;
                    m_rvalid = 1; m_rdata = mem[cap_araddr]; m_rresp = slv_rresp;
                end else if (m_arvalid) begin
                    if (ar_cnt >= ar_delay) m_arready = 1;
                    ar_cnt++;
                end
                if (aw_hs) begin
                    m_awready = 0; aw_cnt = 0; aw_got = 1;
                end else if (m_awvalid) begin
                    if (aw_cnt >= aw_delay) m_awready = 1;
                    aw_cnt++;
                end
                if (w_hs) begin
                    m_wready = 0; w_cnt = 0; w_got = 1;
                end else if (m_wvalid) begin
                    if (w_cnt >= w_delay) m_wready = 1;
                    w_cnt++;
                end
                if (aw_got && w_got && !m_bvalid) begin
                    m_bvalid = 1; m_bresp = slv_bresp; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    task automatic s_read(input int m, input logic [AW-1:0] addr, output int lat);
        int k;
        @(posedge clk);
        #1;
        s_araddr[m] = addr;
        s_arvalid[m] = 1'b1;
        lat = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            lat++;
            if (s_arready[m]) break;
        end
        if (k == 200) timeout("s_read_ar");
        @(posedge clk);
        #1;
        s_arvalid[m] = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_rvalid[m] && s_rready[m]) break;
        end
        if (k == 200) timeout("s_read_r");
        @(posedge clk);
        #1;
    endtask

    task automatic s_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb);
        int   k;
        logic aw_acc, w_acc;
        @(posedge clk);
        #1;
        s_awaddr[m] = addr;
        s_wdata[m] = data;
        s_wstrb[m] = strb;
        s_awvalid[m] = 1'b1;
        s_wvalid[m] = 1'b1;
        for (k = 0; k < 200 && (s_awvalid[m] || s_wvalid[m]); k++) begin
            @(negedge clk);
            aw_acc = s_awvalid[m] & s_awready[m];
            w_acc = s_wvalid[m] & s_wready[m];
            @(posedge clk);
            #1;
            if (aw_acc) s_awvalid[m] = 1'b0;
            if (w_acc) s_wvalid[m] = 1'b0;
        end
        if (k == 200) timeout("s_write_aw_w");
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_bvalid[m] && s_bready[m]) break;
        end
        if (k == 200) timeout("s_write_b");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [14:0] all_vr();
        return {s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
                m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};
    endfunction

    initial begin
        int lat0, lat1, k;
        s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_rready = 2'b11; s_bready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            s_araddr[i] = '0; s_awaddr[i] = '0; s_arprot[i] = '0; s_awprot[i] = '0;
            s_wdata[i] = '0; s_wstrb[i] = '0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h11112222;
        mem[8'h24] = 32'h33334444;
        mem[8'h40] = 32'h0BADF00D;
        mem[8'h60] = 32'hCAFE0060;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_ready", 64'(all_vr()), 64'd0);
        check("reset_m_addr", {m_araddr, m_awaddr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone S0 read: one-cycle arbitration latency, S1 untouched
        s1_act = 0;
        exp_m.push_back({1'b0, 8'h10});
        exp_r0.push_back({2'b00, 32'hDEADBEEF});
        s_read(0, 8'h10, lat0);
        check("s0_read_latency", 64'(lat0), 64'd2);
        check("s1_idle_activity", 64'(s1_act), 64'd0);

        // Simultaneous reads after reset: S0 first, then S1
        do_reset();
        exp_m.push_back({1'b0, 8'h20});
        exp_m.push_back({1'b0, 8'h24});
        exp_r0.push_back({2'b00, 32'h11112222});
        exp_r1.push_back({2'b00, 32'h33334444});
        fork
            s_read(0, 8'h20, lat0);
            s_read(1, 8'h24, lat1);
        join

        // S1 write, W accepted three cycles before AW
        aw_delay = 3;
        wv_cycles = 0;
        exp_m.push_back({1'b1, 8'h04});
        exp_w.push_back({4'hF, 32'hA5A5A5A5});
        exp_b1.push_back(2'b00);
        s_write(1, 8'h04, 32'hA5A5A5A5, 4'hF);
        check("wvalid_cycles", 64'(wv_cycles), 64'd1);
        aw_delay = 0;

        // SLVERR passes through untouched
        slv_bresp = 2'b10;
        exp_m.push_back({1'b1, 8'h08});
        exp_w.push_back({4'h3, 32'h00001234});
        exp_b0.push_back(2'b10);
        s_write(0, 8'h08, 32'h00001234, 4'h3);
        slv_bresp = 2'b00;

        // S0 keeps read and write pending: R, W, R, W
        for (int i = 0; i < 2; i++) begin
            exp_m.push_back({1'b0, 8'h40});
            exp_m.push_back({1'b1, 8'h44});
            exp_r0.push_back({2'b00, 32'h0BADF00D});
            exp_w.push_back({4'hF, 32'h5555AAAA});
            exp_b0.push_back(2'b00);
        end
        fork
            begin
                s_read(0, 8'h40, lat0);
                s_read(0, 8'h40, lat0);
            end
            begin
                s_write(0, 8'h44, 32'h5555AAAA, 4'hF);
                s_write(0, 8'h44, 32'h5555AAAA, 4'hF);
            end
        join

        // Reset in the middle of a read data phase
        s_rready[0] = 1'b0;
        exp_m.push_back({1'b0, 8'h50});
        @(posedge clk);
        #1;
        s_araddr[0] = 8'h50;
        s_arvalid[0] = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_arready[0]) break;
        end
        if (k == 200) timeout("rst_mid_ar");
        @(posedge clk);
        #1;
        s_arvalid[0] = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_rvalid) break;
        end
        if (k == 200) timeout("rst_mid_rvalid");
        check("rd_d_rvalid_forwarded", 64'(s_rvalid[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(all_vr()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_rready[0] = 1'b1;
        exp_m.push_back({1'b0, 8'h60});
        exp_r1.push_back({2'b00, 32'hCAFE0060});
        s_read(1, 8'h60, lat1);
        check("s1_after_reset_latency", 64'(lat1), 64'd2);

        repeat (3) @(negedge clk);
        check("queues_drained", 64'(exp_m.size() + exp_w.size() + exp_r0.size() + exp_r1.size()
                                    + exp_b0.size() + exp_b1.size()), 64'd0);
        check("no_read_write_overlap", 64'(overlap), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axilite_arb2.md
AXILITE_ARB2 -- requirements
Module: axilite_arb2

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, data width of all three ports.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 8, address width of all three ports.
REQ-003 SHALL have AXI_ACLK  in  1  single clock for all ports.
REQ-004 SHALL have AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have S0_AXI_AR*/R*/AW*/W*/B*  slave-side  full AXI-Lite set  upstream port for requester 0 (ARADDR, ARPROT, ARVALID, RREADY, AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY in; ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID out).
REQ-006 SHALL have S1_AXI_*  slave-side  same set as S0  upstream port for requester 1.
REQ-007 SHALL have M_AXI_*  master-side  full AXI-Lite set, directions mirrored  single shared downstream port.

Function
REQ-008 SHALL carry exactly one transaction (read or write) on M_AXI at a time; states IDLE, RD_A, RD_D, WR_AW, WR_B.
REQ-009 Requester i is read-pending when Si_ARVALID=1 and write-pending when Si_AWVALID=1 and Si_WVALID=1.
REQ-010 In IDLE SHALL select the master by round-robin pointer rr: prefer master rr if pending, else the other; rr resets to 0.
REQ-011 Within the selected master, read vs write SHALL alternate via a per-master last_op bit (reset = write, so the first pick is read) when both are pending; otherwise take whichever is pending.
REQ-012 Grant (gnt, op) SHALL be registered on the IDLE decision edge; M-side valids assert the cycle after the request is first seen in IDLE (1-cycle arbitration latency).
REQ-013 RD_A: M_ARADDR/ARPROT/ARVALID = granted S signals; granted S_ARREADY = M_ARREADY; on M AR handshake -> RD_D.
REQ-014 RD_D: granted S_RDATA/RRESP/RVALID = M signals; M_RREADY = granted S_RREADY; on R handshake -> IDLE.
REQ-015 WR_AW: AW and W forwarded independently; aw_done/w_done flags set on the respective M handshakes; that channel's M valid and S ready are forced 0 once its flag is set; -> WR_B when both are done (same-cycle AW and W handshakes allowed).
REQ-016 WR_B: granted S_BRESP/BVALID = M signals; M_BREADY = granted S_BREADY; on B handshake -> IDLE; flags cleared.
REQ-017 On return to IDLE SHALL set rr to the non-granted master and update the granted master's last_op.
REQ-018 Non-granted master SHALL see ARREADY, AWREADY, WREADY, RVALID, BVALID = 0; its RDATA/RRESP/BRESP are 0.
REQ-019 In IDLE all M-side valids and readies SHALL be 0; M address/data outputs are don't-care but driven 0.
REQ-020 A granted master that drops its valid mid-grant is an upstream protocol violation; the block SHALL NOT abort the transaction.
REQ-021 Responses (RRESP/BRESP) SHALL pass through unmodified, including SLVERR/DECERR.

Reset
REQ-022 AXI_ARESETN low SHALL asynchronously force state=IDLE, rr=0, last_op=write for both masters, aw_done=w_done=0, and all valid/ready outputs on every port to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon it with no completion; after release the arbiter starts fresh from IDLE.

Verification
REQ-024 S0 read 0x10 alone, slave ARREADY in 1 cycle, RDATA=0xDEADBEEF -> M_ARVALID 1 cycle after S0_ARVALID; S0 receives 0xDEADBEEF, RRESP=0; S1 sees no activity.
REQ-025 S0 and S1 both issue reads in the same cycle after reset -> S0 served first, then S1; rr alternates; no overlap on M.
REQ-026 S1 write 0x04 data 0xA5A5A5A5 WSTRB=0xF, slave accepts W 3 cycles before AW -> WVALID drops after W handshake; single BVALID returned to S1 only.
REQ-027 S0 holds both read and write pending continuously, S1 idle -> grants alternate R,W,R,W on M.
REQ-028 Assert AXI_ARESETN low during RD_D with M_RVALID=1 -> all outputs 0 immediately (async); after release the next S1 request is granted correctly.
REQ-029 Slave returns BRESP=2'b10 -> S0_BRESP=2'b10 forwarded unchanged.
